// File: rtl/level_pkg.sv
// Shared types and constants for the level sequencer: FSM states, frame counter
// widths and the per-level spawn coordinates.
package level_pkg;

  localparam int FRAME_W = 11;
  localparam int MAG_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAY,
    ST_TRANS,
    ST_WON,
    ST_LOST
  } lvl_state_t;

  localparam logic [FRAME_W-1:0] LVL_X [1:3] = '{11'd100, 11'd300, 11'd500};
  localparam logic [FRAME_W-1:0] LVL_Y [1:3] = '{11'd400, 11'd200, 11'd100};

  // Level 0 is never reached; it falls back to the level-1 spawn point.
  function automatic logic [FRAME_W-1:0] spawn_x(input logic [1:0] lvl);
    case (lvl)
      2'd2:    spawn_x = LVL_X[2];
      2'd3:    spawn_x = LVL_X[3];
      default: spawn_x = LVL_X[1];
    endcase
  endfunction

  function automatic logic [FRAME_W-1:0] spawn_y(input logic [1:0] lvl);
    case (lvl)
      2'd2:    spawn_y = LVL_Y[2];
      2'd3:    spawn_y = LVL_Y[3];
      default: spawn_y = LVL_Y[1];
    endcase
  endfunction

endpackage

// File: rtl/level_sequencer_if.sv
// Signals between the top-level game logic / key mover and the level sequencer.
// The sequencer uses the slave modport; the game logic side uses master.
interface level_sequencer_if;
  import level_pkg::*;

  logic               startOfFrame;
  logic               gameStart;
  logic               keyAtGoal;
  logic               magnetReq;
  logic [1:0]         levelNum;
  logic [FRAME_W-1:0] INITIAL_X;
  logic [FRAME_W-1:0] INITIAL_Y;
  logic               startLevel2;
  logic               startLevel3;
  logic               magnetMode;
  logic [MAG_W-1:0]   magnetLeft;
  logic [FRAME_W-1:0] timeLeft;
  logic               playEnable;
  logic               gameWon;
  logic               gameOver;

  modport master (
    output startOfFrame, gameStart, keyAtGoal, magnetReq,
    input  levelNum, INITIAL_X, INITIAL_Y, startLevel2, startLevel3,
    input  magnetMode, magnetLeft, timeLeft, playEnable, gameWon, gameOver
  );

  modport slave (
    input  startOfFrame, gameStart, keyAtGoal, magnetReq,
    output levelNum, INITIAL_X, INITIAL_Y, startLevel2, startLevel3,
    output magnetMode, magnetLeft, timeLeft, playEnable, gameWon, gameOver
  );

endinterface

// File: rtl/frame_down_counter.sv
// Loadable down counter that steps once per frame when enabled and sticks at 0.
// Reset restores the load value so the counter comes up "full".
module frame_down_counter #(
  parameter int               WIDTH    = 11,
  parameter logic [WIDTH-1:0] LOAD_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             sof_i,
  input  logic             dec_en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = LOAD_VAL;
    end else if (sof_i && dec_en_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= LOAD_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/level_sequencer.sv
// Game-flow controller: walks the key-pushing game through three levels, runs the
// per-level time limit and magnet budget, and issues the key mover reload pulses.
module level_sequencer
  import level_pkg::*;
#(
  parameter int TRANS_FRAMES  = 60,
  parameter int LEVEL_FRAMES  = 1800,
  parameter int MAGNET_FRAMES = 150
) (
  input logic              clk,
  input logic              reset,
  level_sequencer_if.slave bus
);

  lvl_state_t         state_q, state_d;
  logic [1:0]         level_q, level_d;
  logic [FRAME_W-1:0] init_x_q, init_y_q;
  logic               start_l2_q, start_l2_d;
  logic               start_l3_q, start_l3_d;
  logic               magnet_mode_q, magnet_mode_d;
  logic               play_q, won_q, lost_q;

  logic               time_load, time_dec_en, time_zero;
  logic               mag_load, mag_zero;
  logic               trans_load, trans_dec_en, trans_zero, trans_last;
  logic [FRAME_W-1:0] time_cnt, trans_cnt;
  logic [MAG_W-1:0]   mag_cnt;

  frame_down_counter #(
    .WIDTH    (FRAME_W),
    .LOAD_VAL (FRAME_W'(LEVEL_FRAMES))
  ) u_time_cnt (
    .clk      (clk),
    .reset    (reset),
    .load_i   (time_load),
    .sof_i    (bus.startOfFrame),
    .dec_en_i (time_dec_en),
    .count_o  (time_cnt),
    .zero_o   (time_zero)
  );

  frame_down_counter #(
    .WIDTH    (MAG_W),
    .LOAD_VAL (MAG_W'(MAGNET_FRAMES))
  ) u_magnet_cnt (
    .clk      (clk),
    .reset    (reset),
    .load_i   (mag_load),
    .sof_i    (bus.startOfFrame),
    .dec_en_i (magnet_mode_q),
    .count_o  (mag_cnt),
    .zero_o   (mag_zero)
  );

  frame_down_counter #(
    .WIDTH    (FRAME_W),
    .LOAD_VAL (FRAME_W'(TRANS_FRAMES))
  ) u_trans_cnt (
    .clk      (clk),
    .reset    (reset),
    .load_i   (trans_load),
    .sof_i    (bus.startOfFrame),
    .dec_en_i (trans_dec_en),
    .count_o  (trans_cnt),
    .zero_o   (trans_zero)
  );

  // The reload fires on the frame that would take the pause counter to zero, so the
  // pulse lands exactly TRANS_FRAMES frames after the goal frame.
  assign trans_last = trans_zero || (trans_cnt == FRAME_W'(1));

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    time_load    = 1'b0;
    time_dec_en  = 1'b0;
    mag_load     = 1'b0;
    trans_load   = 1'b0;
    trans_dec_en = 1'b0;
    start_l2_d   = 1'b0;
    start_l3_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.gameStart) begin
          state_d   = ST_PLAY;
          time_load = 1'b1;
          mag_load  = 1'b1;
        end
      end

      ST_PLAY: begin
        time_dec_en = !bus.keyAtGoal && !time_zero;
        if (bus.startOfFrame) begin
          if (bus.keyAtGoal && (level_q != 2'd3)) begin
            state_d    = ST_TRANS;
            level_d    = level_q + 2'd1;
            trans_load = 1'b1;
          end else if (bus.keyAtGoal) begin
            state_d = ST_WON;
          end else if (time_zero) begin
            state_d = ST_LOST;
          end
        end
      end

      ST_TRANS: begin
        trans_dec_en = !trans_last;
        if (bus.startOfFrame && trans_last) begin
          state_d    = ST_PLAY;
          time_load  = 1'b1;
          mag_load   = 1'b1;
          start_l2_d = (level_q == 2'd2);
          start_l3_d = (level_q == 2'd3);
        end
      end

      ST_WON, ST_LOST: begin
        if (bus.gameStart) begin
          state_d   = ST_IDLE;
          level_d   = 2'd1;
          time_load = 1'b1;
          mag_load  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Looking at the next state keeps the magnet off from the first cycle outside PLAY.
  assign magnet_mode_d = (state_d == ST_PLAY) && bus.magnetReq && !mag_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      level_q       <= 2'd1;
      init_x_q      <= LVL_X[1];
      init_y_q      <= LVL_Y[1];
      start_l2_q    <= 1'b0;
      start_l3_q    <= 1'b0;
      magnet_mode_q <= 1'b0;
      play_q        <= 1'b0;
      won_q         <= 1'b0;
      lost_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      init_x_q      <= spawn_x(level_d);
      init_y_q      <= spawn_y(level_d);
      start_l2_q    <= start_l2_d;
      start_l3_q    <= start_l3_d;
      magnet_mode_q <= magnet_mode_d;
      play_q        <= (state_d == ST_PLAY);
      won_q         <= (state_d == ST_WON);
      lost_q        <= (state_d == ST_LOST);
    end
  end

  assign bus.levelNum    = level_q;
  assign bus.INITIAL_X   = init_x_q;
  assign bus.INITIAL_Y   = init_y_q;
  assign bus.startLevel2 = start_l2_q;
  assign bus.startLevel3 = start_l3_q;
  assign bus.magnetMode  = magnet_mode_q;
  assign bus.magnetLeft  = mag_cnt;
  assign bus.timeLeft    = time_cnt;
  assign bus.playEnable  = play_q;
  assign bus.gameWon     = won_q;
  assign bus.gameOver    = lost_q;

endmodule
